// File: rtl/proto_pkg.sv
// Shared register-file / debug-dump constants and the dump FSM state type.
// No ports: imported by reg_dump_unit and its helpers.
package proto_pkg;

    localparam int RF_NUM_REGS = 16;
    localparam int RF_ADDR_W   = 4;
    localparam int RF_DATA_W   = 8;

    localparam logic [7:0] DUMP_HEADER = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        FETCH,
        SEND,
        CSUM,
        DONE
    } dump_state_t;

endpackage

// File: rtl/reg_dump_unit_if.sv
// Byte stream toward the debug transport (valid/ready, last on checksum).
// master: drives m_data/m_valid/m_last; slave: drives m_ready.
interface reg_dump_unit_if #(
    parameter int DATA_W = 8
) ();

    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/dump_checksum.sv
// Modulo-2^DATA_W byte accumulator for the dump frame checksum.
// Ports: clk, rst_n (sync, active-low), clear, add_en, din, sum.
module dump_checksum #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              add_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sum
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/reg_dump_unit.sv
// Walks the register file debug port and streams header, data, checksum.
// Ports: clk, rst_n, cpu_paused, dump_req, dbg_ra/dbg_rd, m (stream), busy, done, err.
module reg_dump_unit
    import proto_pkg::*;
#(
    parameter int                 NUM_REGS = RF_NUM_REGS,
    parameter int                 ADDR_W   = RF_ADDR_W,
    parameter int                 DATA_W   = RF_DATA_W,
    parameter int                 READ_LAT = 1,
    parameter logic [DATA_W-1:0]  HEADER   = DATA_W'(DUMP_HEADER)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_paused,
    input  logic               dump_req,
    output logic [ADDR_W-1:0]  dbg_ra,
    input  logic [DATA_W-1:0]  dbg_rd,
    reg_dump_unit_if.master    m,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int LAT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_t        state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_nxt;
    logic [LAT_W-1:0]   lat_q;
    logic [DATA_W-1:0]  data_q;
    logic [DATA_W-1:0]  sum;
    logic               err_q;

    logic last_beat, xfer, abort;
    logic valid_c, last_c, busy_c, done_c;
    logic accept, enter_fetch, capture, to_csum;

    assign idx_nxt   = idx_q + ADDR_W'(1);
    assign last_beat = (lat_q == LAT_W'(READ_LAT));
    assign xfer      = valid_c && m.m_ready;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and state-decoded outputs
    always_comb begin
        state_d = state_q;
        valid_c = 1'b0;
        last_c  = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dump_req && cpu_paused) state_d = HDR;
            end
            HDR: begin
                valid_c = 1'b1;
                busy_c  = 1'b1;
                if (xfer) state_d = FETCH;
            end
            FETCH: begin
                busy_c = 1'b1;
                if (last_beat) state_d = SEND;
            end
            SEND: begin
                valid_c = 1'b1;
                busy_c  = 1'b1;
                if (xfer) state_d = (idx_q == LAST_IDX) ? CSUM : FETCH;
            end
            CSUM: begin
                valid_c = 1'b1;
                last_c  = 1'b1;
                busy_c  = 1'b1;
                if (xfer) state_d = DONE;
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Losing the pause mid-frame wins over any other transition;
        // a byte transferring this cycle still counts for the sink.
        if (busy_c && !cpu_paused) begin
            abort   = 1'b1;
            state_d = IDLE;
        end
    end

    assign accept      = (state_q == IDLE) && (state_d == HDR);
    assign enter_fetch = (state_q != FETCH) && (state_d == FETCH);
    assign capture     = (state_q == FETCH) && (state_d == SEND);
    assign to_csum     = (state_q == SEND) && (state_d == CSUM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q  <= '0;
            lat_q  <= '0;
            dbg_ra <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= abort;
            if (accept) begin
                idx_q  <= '0;
                dbg_ra <= '0;
                data_q <= HEADER;
            end
            if (enter_fetch) begin
                lat_q <= '0;
                if (state_q == SEND) begin
                    idx_q  <= idx_nxt;
                    dbg_ra <= idx_nxt;
                end else begin
                    dbg_ra <= idx_q;
                end
            end else if (state_q == FETCH && !last_beat) begin
                lat_q <= lat_q + LAT_W'(1);
            end
            if (capture) data_q <= dbg_rd;
            if (to_csum) data_q <= sum;
        end
    end

    dump_checksum #(
        .DATA_W (DATA_W)
    ) u_csum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .add_en (capture),
        .din    (dbg_rd),
        .sum    (sum)
    );

    assign m.m_data  = data_q;
    assign m.m_valid = valid_c;
    assign m.m_last  = last_c;
    assign busy      = busy_c;
    assign done      = done_c;
    assign err       = err_q;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Self-checking bench for reg_dump_unit with a synchronous reg_file stub.
// No ports: drives stimulus, compares frames against a frame model.
module tb_reg_dump_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_paused = 1'b0;
    logic       dump_req = 1'b0;
    logic [3:0] dbg_ra;
    logic [7:0] dbg_rd;
    logic       busy, done, err;

    reg_dump_unit_if #(.DATA_W(8)) sif ();

    reg_dump_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_paused (cpu_paused),
        .dump_req   (dump_req),
        .dbg_ra     (dbg_ra),
        .dbg_rd     (dbg_rd),
        .m          (sif),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // register file with one cycle read latency
    logic [7:0] regs [16];
    always @(posedge clk) dbg_rd <= regs[dbg_ra];

    int total = 0;
    int bad = 0;

    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int         last_q [$];
    int n_done, n_err, stall_bad, fv_k, done_k;
    bit timed_out;

    // expected frame: header, the 16 bytes, byte-wide sum of the 16 bytes
    task automatic build_expected();
        int s;
        s = 0;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(regs[i]);
            s = s + int'(regs[i]);
        end
        exp_q.push_back(8'(s % 256));
    endtask

    task automatic pulse_req();
        @(negedge clk);
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
    endtask

    // records transfers, stall stability and done/err until done or err
    task automatic collect(input bit rnd, input int max_cyc);
        bit pv, pr, pl;
        logic [7:0] pd;
        got_q.delete();
        last_q.delete();
        n_done = 0; n_err = 0; stall_bad = 0;
        fv_k = -1; done_k = -1; timed_out = 1;
        pv = 0; pr = 0; pl = 0; pd = 0;
        for (int k = 0; k < max_cyc; k++) begin
            if (pv && !pr) begin
                if (!sif.m_valid || sif.m_data !== pd || sif.m_last !== pl)
                    stall_bad++;
            end
            if (sif.m_valid && fv_k < 0) fv_k = k;
            if (err) begin
                n_err++;
                timed_out = 0;
                break;
            end
            if (done) begin
                n_done++;
                done_k = k;
                timed_out = 0;
                break;
            end
            sif.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sif.m_valid && sif.m_ready) begin
                got_q.push_back(sif.m_data);
                if (sif.m_last) last_q.push_back(got_q.size() - 1);
            end
            pv = sif.m_valid; pr = sif.m_ready;
            pd = sif.m_data;  pl = sif.m_last;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_paused = 1'b0;
        sif.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({dbg_ra, sif.m_data, sif.m_valid, sif.m_last, busy, done, err} !== 17'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                {dbg_ra, sif.m_data, sif.m_valid, sif.m_last, busy, done, err});
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || sif.m_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle busy=%b valid=%b want 0 0", busy, sif.m_valid);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 16; i++) regs[i] = 8'(i * 17);
        build_expected();
        cpu_paused = 1'b1;
        sif.m_ready = 1'b1;
        pulse_req();
        collect(0, 200);
        total++;
        if (timed_out) begin bad++; $display("FAIL basic_timeout got=1 want=0"); end
        total++;
        if (fv_k !== 0) begin bad++; $display("FAIL basic_latency got=%0d want=0", fv_k); end
        total++;
        if (got_q.size() !== 18) begin
            bad++; $display("FAIL basic_count got=%0d want=18", got_q.size());
        end
        for (int i = 0; i < 18 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL basic_byte%0d got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        total++;
        if (last_q.size() != 1 || last_q[0] != 17) begin
            bad++; $display("FAIL basic_last got_n=%0d want one at 17", last_q.size());
        end
        total++;
        if (done_k - fv_k !== 50) begin
            bad++; $display("FAIL basic_done_gap got=%0d want=50", done_k - fv_k);
        end
        total++;
        if (n_err !== 0) begin bad++; $display("FAIL basic_err got=%0d want=0", n_err); end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_after done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_stall(input int mode);
        for (int i = 0; i < 16; i++)
            regs[i] = (mode == 0) ? 8'(i * 17) :
                      (mode == 1) ? 8'hFF : 8'($urandom_range(0, 255));
        build_expected();
        cpu_paused = 1'b1;
        sif.m_ready = 1'($urandom_range(0, 1));
        pulse_req();
        collect(1, 600);
        total++;
        if (timed_out || n_done !== 1 || n_err !== 0) begin
            bad++;
            $display("FAIL stall%0d_end got to=%0d done=%0d err=%0d want 0 1 0",
                mode, timed_out, n_done, n_err);
        end
        total++;
        if (stall_bad !== 0) begin
            bad++; $display("FAIL stall%0d_stable got=%0d want=0", mode, stall_bad);
        end
        total++;
        if (got_q.size() !== 18) begin
            bad++; $display("FAIL stall%0d_count got=%0d want=18", mode, got_q.size());
        end
        for (int i = 0; i < 18 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL stall%0d_byte%0d got=%h want=%h", mode, i, got_q[i], exp_q[i]);
            end
        end
        total++;
        if (last_q.size() != 1 || last_q[0] != 17) begin
            bad++; $display("FAIL stall%0d_last got_n=%0d want one at 17", mode, last_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_not_paused();
        bit seen;
        seen = 0;
        cpu_paused = 1'b0;
        sif.m_ready = 1'b1;
        pulse_req();
        for (int k = 0; k < 10; k++) begin
            if (sif.m_valid || busy || err) seen = 1;
            @(negedge clk);
        end
        total++;
        if (seen) begin bad++; $display("FAIL not_paused_activity got=1 want=0"); end
    endtask

    task automatic test_back_to_back();
        int nd, nv_after;
        logic [7:0] q [$];
        for (int i = 0; i < 16; i++) regs[i] = 8'($urandom_range(0, 255));
        build_expected();
        cpu_paused = 1'b1;
        sif.m_ready = 1'b1;
        pulse_req();
        nd = 0; nv_after = 0;
        for (int k = 0; k < 130; k++) begin
            dump_req = (k == 3 || k == 20 || k == 49);
            if (done) nd++;
            if (sif.m_valid && nd > 0) nv_after++;
            if (sif.m_valid && sif.m_ready) q.push_back(sif.m_data);
            @(negedge clk);
        end
        dump_req = 1'b0;
        total++;
        if (nd !== 1 || nv_after !== 0) begin
            bad++; $display("FAIL b2b_frames got done=%0d extra=%0d want 1 0", nd, nv_after);
        end
        total++;
        if (q.size() !== 18) begin bad++; $display("FAIL b2b_count got=%0d want=18", q.size()); end
        for (int i = 0; i < 18 && i < q.size(); i++) begin
            total++;
            if (q[i] !== exp_q[i]) begin
                bad++; $display("FAIL b2b_byte%0d got=%h want=%h", i, q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_abort();
        int xf;
        bit hit;
        for (int i = 0; i < 16; i++) regs[i] = 8'($urandom_range(0, 255));
        build_expected();
        cpu_paused = 1'b1;
        sif.m_ready = 1'b1;
        pulse_req();
        xf = 0; hit = 0;
        for (int k = 0; k < 200; k++) begin
            if (xf == 5 && sif.m_valid) begin hit = 1; break; end
            sif.m_ready = (xf < 5);
            if (sif.m_valid && sif.m_ready) xf++;
            @(negedge clk);
        end
        total++;
        if (!hit || sif.m_data !== exp_q[5]) begin
            bad++; $display("FAIL abort_pending got hit=%0d data=%h want 1 %h", hit, sif.m_data, exp_q[5]);
        end
        cpu_paused = 1'b0;
        @(negedge clk);
        total++;
        if (sif.m_valid !== 1'b0 || err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_cycle got v=%b e=%b b=%b d=%b want 0 1 0 0",
                sif.m_valid, err, busy, done);
        end
        @(negedge clk);
        total++;
        if (err !== 1'b0 || done !== 1'b0 || sif.m_valid !== 1'b0) begin
            bad++; $display("FAIL abort_after got e=%b d=%b v=%b want 0 0 0", err, done, sif.m_valid);
        end
        cpu_paused = 1'b1;
        sif.m_ready = 1'b1;
        pulse_req();
        collect(0, 200);
        total++;
        if (n_done !== 1 || got_q.size() !== 18) begin
            bad++; $display("FAIL abort_retry got done=%0d n=%0d want 1 18", n_done, got_q.size());
        end
        for (int i = 0; i < 18 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL abort_retry_byte%0d got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int xf;
        bit hit;
        for (int i = 0; i < 16; i++) regs[i] = 8'($urandom_range(1, 255));
        cpu_paused = 1'b1;
        sif.m_ready = 1'b1;
        pulse_req();
        xf = 0; hit = 0;
        for (int k = 0; k < 100; k++) begin
            if (xf >= 3 && busy && !sif.m_valid) begin hit = 1; break; end
            if (sif.m_valid && sif.m_ready) xf++;
            @(negedge clk);
        end
        total++;
        if (!hit) begin bad++; $display("FAIL rst_mid_reach got=0 want=1"); end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({dbg_ra, sif.m_data, sif.m_valid, sif.m_last, busy, done, err} !== 17'd0) begin
            bad++;
            $display("FAIL rst_mid_outputs got=%h want=0",
                {dbg_ra, sif.m_data, sif.m_valid, sif.m_last, busy, done, err});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (err !== 1'b0 || sif.m_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_mid_after got e=%b v=%b b=%b want 0 0 0", err, sif.m_valid, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        sif.m_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall(0);
        test_stall(1);
        for (int r = 0; r < 3; r++) test_stall(2);
        test_not_paused();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_dump_unit.md
Name: reg_dump_unit

Overview:
Debug-side reader for the 16x8 register file. While the CPU is paused, a dump request makes the block walk register addresses 0..15 through a dedicated read port. It streams a framed byte sequence on a valid/ready output toward the debug/host link: header, 16 register bytes, then a checksum. It is the consumer counterpart of the register-file write path and sits between reg_file's debug read port and the debug transport.

Parameters:
NUM_REGS, 16, registers dumped per frame (power of two)
ADDR_W, 4, register address width (log2 NUM_REGS)
DATA_W, 8, register and stream byte width
READ_LAT, 1, cycles from dbg_ra change to valid dbg_rd (0 = combinational read)
HEADER, 8'hA5, first byte of every frame

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
cpu_paused  in  1  CPU halted; dumps start and continue only while high
dump_req  in  1  start request, sampled each cycle
dbg_ra  out  ADDR_W  read address to reg_file debug read port
dbg_rd  in  DATA_W  read data from reg_file debug read port
m_data  out  DATA_W  stream byte
m_valid  out  1  stream byte valid
m_ready  in  1  sink ready; transfer when m_valid && m_ready
m_last  out  1  high with the checksum byte only
busy  out  1  high from accept until return to IDLE
done  out  1  one-cycle pulse after checksum transfer
err  out  1  one-cycle pulse on abort

Behaviour:
- Reset (rst_n=0 at a clk edge) is synchronous active-low and overrides everything. All outputs go to 0 (dbg_ra=0, m_data=0, m_valid=0, m_last=0, busy=0, done=0, err=0). State goes to IDLE and the checksum is cleared. Reset mid-frame drops the frame silently, with no err.
- States: IDLE, HDR, FETCH, SEND, CSUM, DONE.
- IDLE: if dump_req && cpu_paused, go to HDR next cycle with busy=1, idx=0, sum=0. dump_req is ignored when cpu_paused=0 or when not in IDLE (no queuing).
- HDR: m_data=HEADER, m_valid=1. On transfer, go to FETCH.
- FETCH: dbg_ra=idx, held for READ_LAT+1 cycles. dbg_rd is captured on the final cycle's edge into m_data and added into sum; then go to SEND.
- SEND: m_valid=1. On transfer: if idx==NUM_REGS-1 go to CSUM, else idx+1 and go to FETCH.
- CSUM: m_data=sum, m_valid=1, m_last=1. On transfer go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Handshake: m_data and m_last are stable while m_valid && !m_ready. m_valid never drops without a transfer, except on abort or reset. m_valid is low in IDLE, FETCH and DONE.
- Checksum: sum = (sum + byte) mod 2^DATA_W over the 16 register bytes only (header excluded). Overflow wraps.
- dbg_ra holds its last value when not in FETCH and returns to 0 only on reset or frame start.
- Abort: if cpu_paused=0 in any state other than IDLE/DONE, the next cycle gives m_valid=0, m_last=0, busy=0, err=1 for one cycle, then IDLE. This applies even with a byte pending; the sink discards a partial frame on err. If cpu_paused falls in the same cycle a byte transfers, the transfer counts, then the abort follows.
- Latency with m_ready held 1: request at cycle N, header valid in N+1. Total frame is 1 + NUM_REGS*(READ_LAT+2) + 1 beats/cycles, which is 50 cycles with the defaults, and done follows in the next cycle.
- The block never writes the register file.

Decomposition:
- Shared package proto_pkg holds the state enum (IDLE..DONE), the HEADER default, and the ADDR_W/DATA_W width constants used by reg_file and this block.
- One sub-module, dump_checksum, is natural: a DATA_W accumulator with clear and add_en inputs and a sum output.
- FSM, index counter, latency counter and stream register stay in reg_dump_unit.

Test Plan:
- Preload reg i = i*8'h11, cpu_paused=1, m_ready=1, pulse dump_req. Expected stream is A5, 00, 11, ..., FF, then F8 with m_last=1; done pulses 50 cycles after first valid; err never asserts.
- Same preload with m_ready toggling pseudo-randomly. Expected: identical 18-byte sequence, m_data stable during every stall, no byte duplicated or dropped.
- dump_req with cpu_paused=0. Expected: no m_valid, busy stays 0.
- Second dump_req pulses while busy. Expected: exactly one frame output.
- Drop cpu_paused during the 5th data byte with m_ready=0. Expected: next cycle m_valid=0, err=1 for one cycle, busy=0, no done. A subsequent request produces a full correct frame starting with A5.
- Assert rst_n=0 mid-FETCH. Expected: all outputs 0 on the next edge with no err. Also with all registers = FF, checksum = F0 (wrap).
